// File: rtl/priority_scan_coder.sv
// Priority encoder with edge-triggered code history and a multiplexed
// active-low seven-segment scanner that shows the history newest-first.
module priority_scan_coder #(
    parameter int N_IN     = 10,
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            e,
    input  logic            t,
    input  logic [N_IN-1:0] a,
    input  logic [3:0]      b,
    input  logic            load,
    input  logic            clr,
    output logic            f,
    output logic [3:0]      d,
    output logic [N_IN-1:0] y,
    output logic [3:0]      cnt,
    output logic [6:0]      cn,
    output logic            dp,
    output logic [7:0]      an
);

    localparam int W  = 4;
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic [W-1:0]  hist [DIGITS];
    logic [DIGITS-1:0] vld;
    logic [CW-1:0] scan_cnt;
    logic [2:0]    idx;

    logic          f_n;
    logic [W-1:0]  d_n;
    logic          rise;
    logic          push;
    logic [W-1:0]  push_code;

    // Ascending scan so the highest set request line is the last to assign.
    // NOTE: every combinational output is given a default first so no latch is inferred.
    always_comb begin
        f_n = e & (|a);
        d_n = '0;
        if (f_n) begin
            for (int i = 0; i < N_IN; i++) begin
                if (a[i]) d_n = W'(i);
            end
        end
    end

    // A rising encoder-valid edge beats a manual load in the same cycle.
    assign rise      = f_n & ~f;
    assign push      = rise | load;
    assign push_code = rise ? d_n : b;

    // NOTE: state uses non-blocking assignments; the history array is reset
    // explicitly because a blank display must follow reset, not stale codes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f   <= 1'b0;
            d   <= '0;
            cnt <= '0;
            vld <= '0;
            for (int k = 0; k < DIGITS; k++) hist[k] <= '0;
        end else begin
            f <= f_n;
            d <= d_n;
            if (clr) begin
                vld <= '0;
                cnt <= '0;
            end else if (push) begin
                hist[0] <= push_code;
                vld[0]  <= 1'b1;
                for (int k = 1; k < DIGITS; k++) begin
                    hist[k] <= hist[k-1];
                    vld[k]  <= vld[k-1];
                end
                if (cnt != 4'(DIGITS)) cnt <= cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (scan_cnt == CW'(SCAN_DIV - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == 3'(DIGITS - 1)) ? 3'd0 : idx + 3'd1;
        end else begin
            scan_cnt <= scan_cnt + CW'(1);
        end
    end

    assign y = f ? (N_IN'(1) << d) : '0;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    logic [W-1:0] cur_code;
    logic         cur_vld;
    logic [7:0]   an_scan;

    // Display decode depends only on registers; lamp test is the one direct input path.
    always_comb begin
        cur_code = '0;
        cur_vld  = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == 3'(k)) begin
                cur_code = hist[k];
                cur_vld  = vld[k];
            end
        end
        an_scan = 8'hFF;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == 3'(i)) an_scan[i] = 1'b0;
        end
        if (t) begin
            cn = 7'h00;
            dp = 1'b0;
            an = 8'h00;
        end else begin
            cn = cur_vld ? glyph(cur_code) : 7'h7F;
            dp = ~((idx == 3'd0) & vld[0]);
            an = an_scan;
        end
    end

endmodule

// File: tb/tb_priority_scan_coder.sv
// Directed bench for priority_scan_coder (N_IN=10, DIGITS=8, SCAN_DIV=4):
// encoder, push/hold rules, history shift, scanning, lamp test and reset.
module tb_priority_scan_coder;

    logic       clk = 1'b0;
    logic       rst;
    logic       e, t, load, clr;
    logic [9:0] a;
    logic [3:0] b;
    logic       f;
    logic [3:0] d;
    logic [9:0] y;
    logic [3:0] cnt;
    logic [6:0] cn;
    logic       dp;
    logic [7:0] an;

    int n_cmp = 0;
    int n_bad = 0;

    priority_scan_coder #(.N_IN(10), .DIGITS(8), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .e(e), .t(t), .a(a), .b(b), .load(load), .clr(clr),
        .f(f), .d(d), .y(y), .cnt(cnt), .cn(cn), .dp(dp), .an(an)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare helpers are intentionally inline in each test.
    task automatic wait_idx(input int k, input string tag);
        logic [7:0] want;
        bit ok = 0;
        want = ~(8'd1 << k);
        for (int i = 0; i < 40; i++) begin
            if (an === want) begin ok = 1; break; end
            step();
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s wait_idx%0d: an=%h required %h", tag, k, an, want);
        end
    endtask

    task automatic sync_fe(input string tag);
        logic [7:0] prev;
        bit ok = 0;
        prev = an;
        for (int i = 0; i < 40; i++) begin
            step();
            if (an === 8'hFE && prev !== 8'hFE) begin ok = 1; break; end
            prev = an;
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s sync_fe: an=%h never restarted at FE", tag, an);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; e = 0; t = 0; a = '0; b = '0; load = 0; clr = 0;
        step(3);
        n_cmp += 7;
        if (f   !== 1'b0)    begin n_bad++; $display("FAIL reset_f: got %b required 0", f); end
        if (d   !== 4'd0)    begin n_bad++; $display("FAIL reset_d: got %h required 0", d); end
        if (y   !== 10'd0)   begin n_bad++; $display("FAIL reset_y: got %h required 0", y); end
        if (cnt !== 4'd0)    begin n_bad++; $display("FAIL reset_cnt: got %0d required 0", cnt); end
        if (cn  !== 7'h7F)   begin n_bad++; $display("FAIL reset_cn: got %h required 7f", cn); end
        if (dp  !== 1'b1)    begin n_bad++; $display("FAIL reset_dp: got %b required 1", dp); end
        if (an  !== 8'hFE)   begin n_bad++; $display("FAIL reset_an: got %h required fe", an); end
        rst = 1'b0;
    endtask

    task automatic test_encode();
        e = 1; a = 10'b10_0000_0100;
        step();
        n_cmp += 6;
        if (f   !== 1'b1)        begin n_bad++; $display("FAIL enc_f: got %b required 1", f); end
        if (d   !== 4'd9)        begin n_bad++; $display("FAIL enc_d: got %0d required 9", d); end
        if (y   !== 10'h200)     begin n_bad++; $display("FAIL enc_y: got %h required 200", y); end
        if (cnt !== 4'd1)        begin n_bad++; $display("FAIL enc_cnt: got %0d required 1", cnt); end
        if (cn  !== 7'b0010000)  begin n_bad++; $display("FAIL enc_cn: got %b required 0010000", cn); end
        if (dp  !== 1'b0)        begin n_bad++; $display("FAIL enc_dp: got %b required 0", dp); end
        a = 10'b00_0000_0001;
        step();
        n_cmp += 3;
        if (d   !== 4'd0)    begin n_bad++; $display("FAIL enc_low_d: got %0d required 0", d); end
        if (y   !== 10'h001) begin n_bad++; $display("FAIL enc_low_y: got %h required 001", y); end
        if (cnt !== 4'd1)    begin n_bad++; $display("FAIL enc_low_cnt: got %0d required 1", cnt); end
        a = 10'b00_1111_0000;
        step();
        n_cmp += 3;
        if (d   !== 4'd7)    begin n_bad++; $display("FAIL enc_mid_d: got %0d required 7", d); end
        if (y   !== 10'h080) begin n_bad++; $display("FAIL enc_mid_y: got %h required 080", y); end
        if (cnt !== 4'd1)    begin n_bad++; $display("FAIL enc_mid_cnt: got %0d required 1", cnt); end
    endtask

    task automatic test_hold();
        a = 10'b10_0000_0100;
        step(20);
        n_cmp += 2;
        if (cnt !== 4'd1) begin n_bad++; $display("FAIL hold_cnt: got %0d required 1", cnt); end
        if (d   !== 4'd9) begin n_bad++; $display("FAIL hold_d: got %0d required 9", d); end
        e = 0;
        step();
        n_cmp += 4;
        if (f   !== 1'b0)  begin n_bad++; $display("FAIL hold_off_f: got %b required 0", f); end
        if (d   !== 4'd0)  begin n_bad++; $display("FAIL hold_off_d: got %0d required 0", d); end
        if (y   !== 10'd0) begin n_bad++; $display("FAIL hold_off_y: got %h required 0", y); end
        if (cnt !== 4'd1)  begin n_bad++; $display("FAIL hold_off_cnt: got %0d required 1", cnt); end
        e = 1;
        step();
        n_cmp += 2;
        if (f   !== 1'b1) begin n_bad++; $display("FAIL repush_f: got %b required 1", f); end
        if (cnt !== 4'd2) begin n_bad++; $display("FAIL repush_cnt: got %0d required 2", cnt); end
        a = '0;
        step();
        n_cmp += 2;
        if (f   !== 1'b0) begin n_bad++; $display("FAIL no_req_f: got %b required 0", f); end
        if (cnt !== 4'd2) begin n_bad++; $display("FAIL no_req_cnt: got %0d required 2", cnt); end
        e = 0;
    endtask

    task automatic test_clr();
        clr = 1;
        step();
        clr = 0;
        n_cmp++;
        if (cnt !== 4'd0) begin n_bad++; $display("FAIL clr_cnt: got %0d required 0", cnt); end
    endtask

    task automatic test_load_overflow();
        logic [6:0] exp_cn [8];
        exp_cn = '{7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010,
                   7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100};
        for (int v = 0; v < 10; v++) begin
            b = 4'(v); load = 1;
            step();
        end
        load = 0;
        n_cmp++;
        if (cnt !== 4'd8) begin n_bad++; $display("FAIL full_cnt: got %0d required 8", cnt); end
        for (int k = 0; k < 8; k++) begin
            wait_idx(k, "hist");
            n_cmp += 2;
            if (cn !== exp_cn[k])
                begin n_bad++; $display("FAIL hist_cn%0d: got %b required %b", k, cn, exp_cn[k]); end
            if (dp !== (k == 0 ? 1'b0 : 1'b1))
                begin n_bad++; $display("FAIL hist_dp%0d: got %b", k, dp); end
        end
        b = 4'hA; load = 1;
        step();
        load = 0;
        n_cmp++;
        if (cnt !== 4'd8) begin n_bad++; $display("FAIL full_push_cnt: got %0d required 8", cnt); end
        wait_idx(0, "full_push");
        n_cmp++;
        if (cn !== 7'b0001000) begin n_bad++; $display("FAIL full_push_cn0: got %b required 0001000", cn); end
        wait_idx(7, "full_push");
        n_cmp++;
        if (cn !== 7'b0110000) begin n_bad++; $display("FAIL full_push_cn7: got %b required 0110000", cn); end
    endtask

    task automatic test_scan();
        logic [7:0] want;
        clr = 1;
        step();
        clr = 0;
        sync_fe("scan");
        for (int k = 0; k < 8; k++) begin
            want = ~(8'd1 << k);
            for (int c = 0; c < 4; c++) begin
                n_cmp += 2;
                if (an !== want)
                    begin n_bad++; $display("FAIL scan_an d%0d c%0d: got %h required %h", k, c, an, want); end
                if (cn !== 7'h7F)
                    begin n_bad++; $display("FAIL scan_cn d%0d c%0d: got %h required 7f", k, c, cn); end
                step();
            end
        end
        n_cmp++;
        if (an !== 8'hFE) begin n_bad++; $display("FAIL scan_wrap: got %h required fe", an); end
    endtask

    task automatic test_collision();
        e = 0; a = '0;
        step();
        e = 1; a = 10'h020; load = 1; b = 4'd3; clr = 1;
        step();
        n_cmp += 3;
        if (cnt !== 4'd0) begin n_bad++; $display("FAIL col_clr_cnt: got %0d required 0", cnt); end
        if (f   !== 1'b1) begin n_bad++; $display("FAIL col_clr_f: got %b required 1", f); end
        if (cn  !== 7'h7F) begin n_bad++; $display("FAIL col_clr_cn: got %h required 7f", cn); end
        e = 0; load = 0; clr = 0;
        step();
        e = 1; a = 10'h040; load = 1; b = 4'd3;
        step();
        load = 0;
        n_cmp += 2;
        if (cnt !== 4'd1) begin n_bad++; $display("FAIL col_push_cnt: got %0d required 1", cnt); end
        if (d   !== 4'd6) begin n_bad++; $display("FAIL col_push_d: got %0d required 6", d); end
        wait_idx(0, "col");
        n_cmp += 2;
        if (cn !== 7'b0000010) begin n_bad++; $display("FAIL col_cn0: got %b required 0000010", cn); end
        if (dp !== 1'b0)       begin n_bad++; $display("FAIL col_dp0: got %b required 0", dp); end
        wait_idx(1, "col");
        n_cmp++;
        if (cn !== 7'h7F) begin n_bad++; $display("FAIL col_cn1: got %h required 7f", cn); end
    endtask

    task automatic test_lamp();
        sync_fe("lamp");
        t = 1;
        #1;
        n_cmp += 3;
        if (cn !== 7'h00) begin n_bad++; $display("FAIL lamp_cn: got %h required 00", cn); end
        if (dp !== 1'b0)  begin n_bad++; $display("FAIL lamp_dp: got %b required 0", dp); end
        if (an !== 8'h00) begin n_bad++; $display("FAIL lamp_an: got %h required 00", an); end
        step(6);
        n_cmp += 2;
        if (an  !== 8'h00) begin n_bad++; $display("FAIL lamp_hold_an: got %h required 00", an); end
        if (cnt !== 4'd1)  begin n_bad++; $display("FAIL lamp_cnt: got %0d required 1", cnt); end
        t = 0;
        #1;
        n_cmp += 3;
        if (an !== 8'hFD) begin n_bad++; $display("FAIL lamp_resume_an: got %h required fd", an); end
        if (cn !== 7'h7F) begin n_bad++; $display("FAIL lamp_resume_cn: got %h required 7f", cn); end
        if (dp !== 1'b1)  begin n_bad++; $display("FAIL lamp_resume_dp: got %b required 1", dp); end
        step(26);
        n_cmp += 3;
        if (an !== 8'hFE)      begin n_bad++; $display("FAIL lamp_wrap_an: got %h required fe", an); end
        if (cn !== 7'b0000010) begin n_bad++; $display("FAIL lamp_wrap_cn: got %b required 0000010", cn); end
        if (dp !== 1'b0)       begin n_bad++; $display("FAIL lamp_wrap_dp: got %b required 0", dp); end
    endtask

    task automatic test_reset_mid();
        e = 0; a = '0; load = 1; b = 4'd5;
        #2;
        rst = 1;
        #1;
        n_cmp += 4;
        if (cnt !== 4'd0)  begin n_bad++; $display("FAIL rmid_cnt: got %0d required 0", cnt); end
        if (f   !== 1'b0)  begin n_bad++; $display("FAIL rmid_f: got %b required 0", f); end
        if (an  !== 8'hFE) begin n_bad++; $display("FAIL rmid_an: got %h required fe", an); end
        if (cn  !== 7'h7F) begin n_bad++; $display("FAIL rmid_cn: got %h required 7f", cn); end
        step();
        rst = 0; load = 0;
        step();
        n_cmp += 2;
        if (cnt !== 4'd0) begin n_bad++; $display("FAIL rmid_after_cnt: got %0d required 0", cnt); end
        if (dp  !== 1'b1) begin n_bad++; $display("FAIL rmid_after_dp: got %b required 1", dp); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_hold();
        test_clr();
        test_load_overflow();
        test_scan();
        test_collision();
        test_lamp();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
